// File: rtl/sram_pixel_reader.sv
// -----------------------------------------------------------------------------
// sram_pixel_reader
//
// Read stage of the camera SRAM frame buffer. On jpeg_start the frame is walked
// tile by tile (tile rows, then tile columns, then rows inside a tile, then
// 32-bit words inside a tile row). Each word is fetched from the SRAM, split
// into four 8-bit pixels (byte [31:24] first) and streamed to the encoder over
// a valid/ready handshake.
//
// Per word: ADDR (address setup) -> WAIT (capture data) -> EMIT (4 pixels).
//
// Ports:
//   clk_100         in   system clock
//   rst             in   asynchronous active-low reset
//   jpeg_start      in   one-cycle pulse, frame ready in SRAM (ignored when busy)
//   data_from_sram  in   32-bit SRAM read data
//   address_to_sram out  18-bit registered SRAM word address
//   pixel_out       out  8-bit pixel sample
//   pixel_valid     out  pixel_out is valid
//   pixel_ready     in   consumer accepts pixel_out this cycle
//   tile_sop        out  first pixel of a tile
//   tile_eop        out  last pixel of a tile
//   frame_done      out  one-cycle pulse after the last pixel of the frame
//   busy            out  high whenever the reader is not idle
//
// Build option:
//   DC_LEVEL_SHIFT_EN  when defined, pixel_out carries raw byte - 128 as 8-bit
//                      two's complement (JPEG2000 DC level shift); otherwise
//                      the raw unsigned byte.
// -----------------------------------------------------------------------------
module sram_pixel_reader #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int TILE_W = 64,
    parameter int TILE_H = 64
) (
    input  logic        clk_100,
    input  logic        rst,
    input  logic        jpeg_start,
    input  logic [31:0] data_from_sram,
    output logic [17:0] address_to_sram,
    output logic [7:0]  pixel_out,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic        tile_sop,
    output logic        tile_eop,
    output logic        frame_done,
    output logic        busy
);

    // Counter ranges, innermost first
    localparam int X_N = TILE_W / 4;
    localparam int Y_N = TILE_H;
    localparam int C_N = IMG_W / TILE_W;
    localparam int R_N = IMG_H / TILE_H;

    localparam int XW = (X_N > 1) ? $clog2(X_N) : 1;
    localparam int YW = (Y_N > 1) ? $clog2(Y_N) : 1;
    localparam int CW = (C_N > 1) ? $clog2(C_N) : 1;
    localparam int RW = (R_N > 1) ? $clog2(R_N) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(X_N - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_N - 1);
    localparam logic [CW-1:0] C_LAST = CW'(C_N - 1);
    localparam logic [RW-1:0] R_LAST = RW'(R_N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [XW-1:0]  r_x_word;
    logic [YW-1:0]  r_y;
    logic [CW-1:0]  r_tile_col;
    logic [RW-1:0]  r_tile_row;
    logic [1:0]     r_byte_idx;
    logic [31:0]    r_word_buf;
    logic [17:0]    r_addr;

    logic           w_hs;
    logic           w_word_end;
    logic           w_x_last;
    logic           w_y_last;
    logic           w_c_last;
    logic           w_r_last;
    logic           w_frame_last;
    logic [XW-1:0]  w_x_nxt;
    logic [YW-1:0]  w_y_nxt;
    logic [CW-1:0]  w_c_nxt;
    logic [RW-1:0]  w_r_nxt;
    logic [7:0]     w_raw_byte;

    // Word address of a counter tuple, truncated to the SRAM address width
    function automatic logic [17:0] f_word_addr(
        input logic [RW-1:0] tr,
        input logic [CW-1:0] tc,
        input logic [YW-1:0] yy,
        input logic [XW-1:0] xw
    );
        int unsigned acc;
        acc = (32'(tr) * TILE_H + 32'(yy)) * (IMG_W / 4)
            + 32'(tc) * (TILE_W / 4) + 32'(xw);
        return acc[17:0];
    endfunction

    // ---------------------------------------------------------------------
    // Handshake and counter carry chain
    // ---------------------------------------------------------------------
    assign w_hs         = (r_state == S_EMIT) && pixel_ready;
    assign w_word_end   = w_hs && (r_byte_idx == 2'd3);

    assign w_x_last     = (r_x_word   == X_LAST);
    assign w_y_last     = (r_y        == Y_LAST);
    assign w_c_last     = (r_tile_col == C_LAST);
    assign w_r_last     = (r_tile_row == R_LAST);
    assign w_frame_last = w_x_last && w_y_last && w_c_last && w_r_last;

    assign w_x_nxt = w_x_last ? '0 : r_x_word + XW'(1);
    assign w_y_nxt = !w_x_last ? r_y
                   : (w_y_last ? '0 : r_y + YW'(1));
    assign w_c_nxt = !(w_x_last && w_y_last) ? r_tile_col
                   : (w_c_last ? '0 : r_tile_col + CW'(1));
    assign w_r_nxt = !(w_x_last && w_y_last && w_c_last) ? r_tile_row
                   : (w_r_last ? '0 : r_tile_row + RW'(1));

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking assignments so all
    // registers see pre-edge values regardless of process ordering.
    always_ff @(posedge clk_100 or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    // NOTE: default assignment first so no path through the case leaves the
    // signal unassigned (which would infer a latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (jpeg_start) w_state_nxt = S_ADDR;
            S_ADDR: w_state_nxt = S_WAIT;
            S_WAIT: w_state_nxt = S_EMIT;
            S_EMIT: if (w_word_end) w_state_nxt = w_frame_last ? S_DONE : S_ADDR;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath: counters, address, word buffer, byte index
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_100 or negedge rst) begin
        if (!rst) begin
            r_x_word   <= '0;
            r_y        <= '0;
            r_tile_col <= '0;
            r_tile_row <= '0;
            r_byte_idx <= '0;
            r_word_buf <= '0;
            r_addr     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Always restart from the frame origin
                    if (jpeg_start) begin
                        r_x_word   <= '0;
                        r_y        <= '0;
                        r_tile_col <= '0;
                        r_tile_row <= '0;
                        r_addr     <= '0;
                    end
                end
                S_WAIT: begin
                    // Address has had ADDR + WAIT to settle; capture the word
                    r_word_buf <= data_from_sram;
                    r_byte_idx <= '0;
                end
                S_EMIT: begin
                    if (w_hs) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                    end
                    // Load the following word address on the edge entering ADDR
                    if (w_word_end) begin
                        r_x_word   <= w_x_nxt;
                        r_y        <= w_y_nxt;
                        r_tile_col <= w_c_nxt;
                        r_tile_row <= w_r_nxt;
                        r_addr     <= f_word_addr(w_r_nxt, w_c_nxt, w_y_nxt, w_x_nxt);
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // FSM: output logic
    // ---------------------------------------------------------------------
    always_comb begin
        case (r_byte_idx)
            2'd0:    w_raw_byte = r_word_buf[31:24];
            2'd1:    w_raw_byte = r_word_buf[23:16];
            2'd2:    w_raw_byte = r_word_buf[15:8];
            default: w_raw_byte = r_word_buf[7:0];
        endcase
    end

    always_comb begin
        pixel_valid = 1'b0;
        pixel_out   = '0;
        tile_sop    = 1'b0;
        tile_eop    = 1'b0;
        frame_done  = (r_state == S_DONE);
        busy        = (r_state != S_IDLE);
        if (r_state == S_EMIT) begin
            pixel_valid = 1'b1;
`ifdef DC_LEVEL_SHIFT_EN
            // Subtracting 128 modulo 256 is an MSB inversion
            pixel_out   = {~w_raw_byte[7], w_raw_byte[6:0]};
`else
            pixel_out   = w_raw_byte;
`endif
            tile_sop    = (r_x_word == '0) && (r_y == '0) && (r_byte_idx == 2'd0);
            tile_eop    = w_x_last && w_y_last && (r_byte_idx == 2'd3);
        end
    end

    assign address_to_sram = r_addr;

endmodule

// File: tb/tb_sram_pixel_reader.sv
// -----------------------------------------------------------------------------
// tb_sram_pixel_reader
//
// Bench for sram_pixel_reader on a 16x8 image with 8x4 tiles. The expected
// pixel stream is derived from tile/pixel coordinates and an SRAM content
// function, and a negedge monitor compares every valid pixel, the tile flags,
// the SRAM address and the frame_done/busy timing against it.
// -----------------------------------------------------------------------------
module tb_sram_pixel_reader;

    localparam int IMG_W  = 16;
    localparam int IMG_H  = 8;
    localparam int TILE_W = 8;
    localparam int TILE_H = 4;
    localparam int NPIX   = IMG_W * IMG_H;

    logic        clk_100     = 1'b0;
    logic        rst         = 1'b0;
    logic        jpeg_start  = 1'b0;
    logic        pixel_ready = 1'b0;
    logic [31:0] data_from_sram;
    logic [17:0] address_to_sram;
    logic [7:0]  pixel_out;
    logic        pixel_valid;
    logic        tile_sop;
    logic        tile_eop;
    logic        frame_done;
    logic        busy;

    sram_pixel_reader #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .TILE_W (TILE_W),
        .TILE_H (TILE_H)
    ) dut (
        .clk_100         (clk_100),
        .rst             (rst),
        .jpeg_start      (jpeg_start),
        .data_from_sram  (data_from_sram),
        .address_to_sram (address_to_sram),
        .pixel_out       (pixel_out),
        .pixel_valid     (pixel_valid),
        .pixel_ready     (pixel_ready),
        .tile_sop        (tile_sop),
        .tile_eop        (tile_eop),
        .frame_done      (frame_done),
        .busy            (busy)
    );

    always #5 clk_100 = ~clk_100;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  pix;
        logic        sop;
        logic        eop;
        logic [17:0] addr;
    } exp_t;

    exp_t        exp_q[$];
    logic [17:0] model_addr[$];

    bit          const_data = 1'b1;
    logic [31:0] salt       = '0;
    int          ready_mode = 0;   // 0: ready=1, 1: random, 2: ready=0
    int          hs_count   = 0;
    int          done_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // SRAM content
    function automatic logic [31:0] sram_word(input logic [17:0] a);
        if (const_data) return 32'h11223344;
        return (32'(a) * 32'h9E3779B1) ^ salt;
    endfunction

    assign data_from_sram = const_data ? 32'h11223344
                                       : ((32'(address_to_sram) * 32'h9E3779B1) ^ salt);

    function automatic logic [7:0] level_shift(input logic [7:0] raw);
`ifdef DC_LEVEL_SHIFT_EN
        return raw - 8'd128;
`else
        return raw;
`endif
    endfunction

    // Expected stream from image geometry: tiles in raster order, pixels in
    // raster order inside a tile, four pixels per SRAM word.
    task automatic build_model();
        exp_t e;
        exp_q.delete();
        model_addr.delete();
        for (int tr = 0; tr < IMG_H / TILE_H; tr++)
            for (int tc = 0; tc < IMG_W / TILE_W; tc++)
                for (int y = 0; y < TILE_H; y++)
                    for (int px = 0; px < TILE_W; px += 4) begin
                        int          row;
                        int          col;
                        logic [17:0] a;
                        logic [31:0] w;
                        row = tr * TILE_H + y;
                        col = tc * TILE_W + px;
                        a   = 18'(row * (IMG_W / 4) + col / 4);
                        model_addr.push_back(a);
                        w   = sram_word(a);
                        for (int b = 0; b < 4; b++) begin
                            int pin;
                            pin    = y * TILE_W + px + b;
                            e.pix  = level_shift(w[31 - 8 * b -: 8]);
                            e.sop  = (pin == 0);
                            e.eop  = (pin == TILE_W * TILE_H - 1);
                            e.addr = a;
                            exp_q.push_back(e);
                        end
                    end
    endtask

    // pixel_ready driver, changes just after the rising edge
    initial begin
        forever begin
            @(posedge clk_100);
            #1;
            case (ready_mode)
                0:       pixel_ready = 1'b1;
                1:       pixel_ready = 1'($urandom_range(0, 1));
                default: pixel_ready = 1'b0;
            endcase
        end
    end

    // Compare process, samples on the falling edge
    initial begin
        bit          exp_done  = 1'b0;
        bit          next_done;
        bit          prev_done = 1'b0;
        bit          prev_stall = 1'b0;
        logic [7:0]  prev_pix  = '0;
        logic        prev_sop  = 1'b0;
        logic        prev_eop  = 1'b0;
        logic [17:0] prev_addr = '0;
        exp_t        e;
        forever begin
            @(negedge clk_100);
            if (!rst) begin
                exp_done   = 1'b0;
                prev_done  = 1'b0;
                prev_stall = 1'b0;
            end else begin
                check("frame_done", frame_done, exp_done);
                if (frame_done) done_count++;
                if (prev_done) check("busy_after_done", busy, 1'b0);
                if (frame_done) check("busy_during_done", busy, 1'b1);
                prev_done = frame_done;
                next_done = 1'b0;
                if (prev_stall) begin
                    check("hold_valid", pixel_valid, 1'b1);
                    check("hold_pixel", pixel_out, prev_pix);
                    check("hold_sop", tile_sop, prev_sop);
                    check("hold_eop", tile_eop, prev_eop);
                    check("hold_addr", address_to_sram, prev_addr);
                end
                if (pixel_valid) begin
                    check("busy_while_valid", busy, 1'b1);
                    check("pixel_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q[0];
                        check("pixel_out", pixel_out, e.pix);
                        check("tile_sop", tile_sop, e.sop);
                        check("tile_eop", tile_eop, e.eop);
                        check("address", address_to_sram, e.addr);
                        if (pixel_ready) begin
                            void'(exp_q.pop_front());
                            hs_count++;
                            if (exp_q.size() == 0) next_done = 1'b1;
                        end
                    end
                    prev_stall = !pixel_ready;
                    prev_pix   = pixel_out;
                    prev_sop   = tile_sop;
                    prev_eop   = tile_eop;
                    prev_addr  = address_to_sram;
                end else begin
                    prev_stall = 1'b0;
                end
                exp_done = next_done;
            end
        end
    end

    task automatic start_frame();
        build_model();
        hs_count = 0;
        @(posedge clk_100); #2 jpeg_start = 1'b1;
        @(posedge clk_100); #2 jpeg_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int start_cnt;
        int n;
        start_cnt = done_count;
        n = 0;
        while (done_count == start_cnt && n < limit) begin
            @(posedge clk_100); #2;
            n++;
        end
        check({name, "_done_in_time"}, 32'(done_count > start_cnt), 1);
        check({name, "_pixels"}, hs_count, NPIX);
    endtask

    task automatic wait_hs(input int target, input int limit);
        int n;
        n = 0;
        while (hs_count < target && n < limit) begin
            @(posedge clk_100); #2;
            n++;
        end
        check("reach_handshake", hs_count, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},       address_to_sram, 0);
        check({tag, "_pixel"},      pixel_out, 0);
        check({tag, "_valid"},      pixel_valid, 0);
        check({tag, "_sop"},        tile_sop, 0);
        check({tag, "_eop"},        tile_eop, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_busy"},       busy, 0);
    endtask

    initial begin
        int         lit_addr[20] = '{0, 1, 4, 5, 8, 9, 12, 13, 2, 3,
                                     6, 7, 10, 11, 14, 15, 16, 17, 20, 21};
        logic [7:0] lit_p0;
        logic [7:0] lit_p3;
        int         dc0;
`ifdef DC_LEVEL_SHIFT_EN
        lit_p0 = 8'h91;
        lit_p3 = 8'hC4;
`else
        lit_p0 = 8'h11;
        lit_p3 = 8'h44;
`endif

        // Reset state
        repeat (3) @(negedge clk_100);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Pin the model against hand-derived values
        const_data = 1'b1;
        build_model();
        check("model_words", model_addr.size(), NPIX / 4);
        for (int i = 0; i < 20; i++) check("model_addr_seq", 32'(model_addr[i]), lit_addr[i]);
        check("model_last_addr", 32'(model_addr[NPIX / 4 - 1]), 31);
        check("model_pix0", exp_q[0].pix, lit_p0);
        check("model_pix3", exp_q[3].pix, lit_p3);
        for (int t = 0; t < 4; t++) begin
            check("model_sop", exp_q[t * 32].sop, 1'b1);
            check("model_eop", exp_q[t * 32 + 31].eop, 1'b1);
        end

        // Frame 1: constant data, latency, mid-word stall
        ready_mode = 0;
        start_frame();
        @(negedge clk_100);
        check("lat_addr_valid", pixel_valid, 1'b0);
        check("lat_addr_busy", busy, 1'b1);
        check("lat_addr_address", address_to_sram, 0);
        @(negedge clk_100);
        check("lat_wait_valid", pixel_valid, 1'b0);
        @(negedge clk_100);
        check("lat_emit_valid", pixel_valid, 1'b1);
        check("lat_emit_pixel", pixel_out, lit_p0);
        check("lat_emit_sop", tile_sop, 1'b1);

        wait_hs(6, 200);
        ready_mode  = 2;
        pixel_ready = 1'b0;
        repeat (5) begin
            @(posedge clk_100); #2;
            check("stall_addr", address_to_sram, 1);
            check("stall_count", hs_count, 6);
        end
        ready_mode  = 0;
        pixel_ready = 1'b1;
        wait_done("frame1", 2000);
        check("frame1_pulses", done_count, 1);

        // Frame 2: random data, random ready, jpeg_start re-pulsed while busy
        repeat (3) @(posedge clk_100);
        #2;
        const_data = 1'b0;
        salt       = $urandom;
        ready_mode = 1;
        start_frame();
        repeat (40) @(posedge clk_100);
        #2 jpeg_start = 1'b1;
        @(posedge clk_100); #2 jpeg_start = 1'b0;
        wait_done("frame2", 5000);
        check("frame2_pulses", done_count, 2);

        // Frame 3: reset asserted during word 5
        repeat (3) @(posedge clk_100);
        #2;
        salt       = $urandom;
        ready_mode = 0;
        start_frame();
        wait_hs(21, 500);
        check("mid_reset_valid_before", pixel_valid, 1'b1);
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        repeat (3) @(posedge clk_100);
        #2 rst = 1'b1;
        dc0 = done_count;
        repeat (12) @(posedge clk_100);
        #2;
        check("no_done_after_reset", done_count, dc0);
        check("idle_after_reset", busy, 1'b0);

        // Frame 4: restart from address 0 with random ready
        ready_mode = 1;
        start_frame();
        wait_done("frame4", 5000);
        check("frame4_pulses", done_count, dc0 + 1);

        repeat (4) @(posedge clk_100);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL timeout: simulation limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
